// File: rtl/operand_fwd_scoreboard_pkg.sv
// Shared encodings for the operand-forwarding scoreboard: producer source kinds
// and the operand-select encoding (0 = register file, k+1 = slot k).
package operand_fwd_scoreboard_pkg;

  localparam int DEST_SRC_W = 2;

  typedef enum logic [DEST_SRC_W-1:0] {
    DEST_SRC_NONE = 2'd0,
    DEST_SRC_ALU  = 2'd1,
    DEST_SRC_MEM  = 2'd2
  } dest_src_e;

  localparam int SEL_RF = 0;

  function automatic int sel_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/operand_fwd_scoreboard_if.sv
// Decode-side bundle of the forwarding scoreboard: issue, operand requests,
// forwarding data in, resolved operands / hazard / stall count out.
interface operand_fwd_scoreboard_if
  import operand_fwd_scoreboard_pkg::*;
#(
  parameter int REG_IDX_W  = 5,
  parameter int WORD_W     = 32,
  parameter int N_SRC      = 2,
  parameter int PIPE_DEPTH = 3,
  parameter int CNT_W      = 32
);
  localparam int SEL_W = sel_width(PIPE_DEPTH);

  logic                         i_issue_valid;
  logic [REG_IDX_W-1:0]         i_issue_dest;
  logic [DEST_SRC_W-1:0]        i_issue_src;
  logic                         i_flush;
  logic [N_SRC*REG_IDX_W-1:0]   i_src_reg;
  logic [N_SRC-1:0]             i_src_used;
  logic [N_SRC*WORD_W-1:0]      i_rf_data;
  logic [PIPE_DEPTH*WORD_W-1:0] i_slot_data;
  logic [N_SRC*WORD_W-1:0]      o_src_data;
  logic [N_SRC*SEL_W-1:0]       o_src_sel;
  logic                         o_hazard;
  logic [CNT_W-1:0]             o_stall_cnt;

  modport master (
    output i_issue_valid, i_issue_dest, i_issue_src, i_flush,
           i_src_reg, i_src_used, i_rf_data, i_slot_data,
    input  o_src_data, o_src_sel, o_hazard, o_stall_cnt
  );

  modport slave (
    input  i_issue_valid, i_issue_dest, i_issue_src, i_flush,
           i_src_reg, i_src_used, i_rf_data, i_slot_data,
    output o_src_data, o_src_sel, o_hazard, o_stall_cnt
  );
endinterface

// File: rtl/operand_fwd_scoreboard_fwd_operand_resolve.sv
// Single-operand resolver: finds the youngest in-flight writer of src_reg and
// forwards its slot data, or flags a load-use hazard if the load is not ready.
module fwd_operand_resolve #(
  parameter int REG_IDX_W      = 5,
  parameter int WORD_W         = 32,
  parameter int PIPE_DEPTH     = 3,
  parameter int MEM_READY_SLOT = 1,
  parameter int SEL_W          = 2
) (
  input  logic                         src_used,
  input  logic [REG_IDX_W-1:0]         src_reg,
  input  logic [WORD_W-1:0]            rf_data,
  input  logic [PIPE_DEPTH-1:0]        slot_valid,
  input  logic [PIPE_DEPTH-1:0]        slot_is_mem,
  input  logic [PIPE_DEPTH*REG_IDX_W-1:0] slot_dest,
  input  logic [PIPE_DEPTH*WORD_W-1:0] slot_data,
  output logic [WORD_W-1:0]            src_data,
  output logic [SEL_W-1:0]             src_sel,
  output logic                         hazard
);
  logic [PIPE_DEPTH-1:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < PIPE_DEPTH; gi++) begin : g_hit
      assign hit[gi] = slot_valid[gi] && (slot_dest[gi*REG_IDX_W +: REG_IDX_W] == src_reg);
    end
  endgenerate

  // Scan oldest to youngest so the lowest matching slot overrides everything older.
  always_comb begin
    src_data = rf_data;
    src_sel  = '0;
    hazard   = 1'b0;
    if (src_used && (src_reg != '0)) begin
      for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
        if (hit[k]) begin
          if (slot_is_mem[k] && (k < MEM_READY_SLOT)) begin
            hazard   = 1'b1;
            src_sel  = '0;
            src_data = '0;
          end else begin
            hazard   = 1'b0;
            src_sel  = SEL_W'(k + 1);
            src_data = slot_data[k*WORD_W +: WORD_W];
          end
        end
      end
    end
  end
endmodule

// File: rtl/operand_fwd_scoreboard.sv
// Decode-side forwarding / load-use unit: shift-register scoreboard of
// in-flight writers, one resolver per source operand, saturating stall counter.
module operand_fwd_scoreboard
  import operand_fwd_scoreboard_pkg::*;
#(
  parameter int REG_IDX_W      = 5,
  parameter int WORD_W         = 32,
  parameter int N_SRC          = 2,
  parameter int PIPE_DEPTH     = 3,
  parameter int MEM_READY_SLOT = 1,
  parameter int CNT_W          = 32
) (
  input logic clk,
  input logic aresetn,
  operand_fwd_scoreboard_if.slave bus
);
  localparam int SEL_W = sel_width(PIPE_DEPTH);

  logic [PIPE_DEPTH-1:0]           slot_valid_reg;
  logic [PIPE_DEPTH*REG_IDX_W-1:0] slot_dest_reg;
  dest_src_e                       slot_src_reg [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0]           slot_is_mem;
  logic [CNT_W-1:0]                stall_cnt_reg;
  logic [N_SRC-1:0]                operand_hazard;
  logic [N_SRC*WORD_W-1:0]         src_data;
  logic [N_SRC*SEL_W-1:0]          src_sel;
  logic                            hazard;
  logic                            issue_ok;

  genvar gi;
  generate
    for (gi = 0; gi < PIPE_DEPTH; gi++) begin : g_is_mem
      assign slot_is_mem[gi] = (slot_src_reg[gi] == DEST_SRC_MEM);
    end

    for (gi = 0; gi < N_SRC; gi++) begin : g_src
      fwd_operand_resolve #(
        .REG_IDX_W      (REG_IDX_W),
        .WORD_W         (WORD_W),
        .PIPE_DEPTH     (PIPE_DEPTH),
        .MEM_READY_SLOT (MEM_READY_SLOT),
        .SEL_W          (SEL_W)
      ) u_resolve (
        .src_used    (bus.i_src_used[gi]),
        .src_reg     (bus.i_src_reg[gi*REG_IDX_W +: REG_IDX_W]),
        .rf_data     (bus.i_rf_data[gi*WORD_W +: WORD_W]),
        .slot_valid  (slot_valid_reg),
        .slot_is_mem (slot_is_mem),
        .slot_dest   (slot_dest_reg),
        .slot_data   (bus.i_slot_data),
        .src_data    (src_data[gi*WORD_W +: WORD_W]),
        .src_sel     (src_sel[gi*SEL_W +: SEL_W]),
        .hazard      (operand_hazard[gi])
      );
    end
  endgenerate

  assign hazard = |operand_hazard;

  // x0 writes and non-writing instructions never enter the scoreboard.
  assign issue_ok = bus.i_issue_valid && !hazard && (bus.i_issue_dest != '0) &&
                    (bus.i_issue_src != DEST_SRC_W'(DEST_SRC_NONE));

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      slot_valid_reg <= '0;
      slot_dest_reg  <= '0;
      for (int k = 0; k < PIPE_DEPTH; k++) slot_src_reg[k] <= DEST_SRC_NONE;
      stall_cnt_reg  <= '0;
    end else begin
      for (int k = PIPE_DEPTH - 1; k > 0; k--) begin
        slot_valid_reg[k] <= slot_valid_reg[k-1] && !(bus.i_flush && (k == 1));
        slot_dest_reg[k*REG_IDX_W +: REG_IDX_W] <= slot_dest_reg[(k-1)*REG_IDX_W +: REG_IDX_W];
        slot_src_reg[k] <= slot_src_reg[k-1];
      end
      slot_valid_reg[0]             <= issue_ok;
      slot_dest_reg[0 +: REG_IDX_W] <= bus.i_issue_dest;
      slot_src_reg[0]               <= dest_src_e'(bus.i_issue_src);
      if (hazard && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign bus.o_src_data  = src_data;
  assign bus.o_src_sel   = src_sel;
  assign bus.o_hazard    = hazard;
  assign bus.o_stall_cnt = stall_cnt_reg;
endmodule

// File: tb/tb_operand_fwd_scoreboard.sv
// Directed bench: a 3-deep / 2-bit-counter instance driven from a vector table,
// plus hand sequences for async reset and a 5-deep instance with late load data.
module tb_operand_fwd_scoreboard;
  import operand_fwd_scoreboard_pkg::*;

  localparam logic [31:0] RF0 = 32'h1111_1111;
  localparam logic [31:0] RF1 = 32'h2222_2222;
  localparam logic [31:0] S0  = 32'h0000_1234;
  localparam logic [31:0] S1  = 32'h0000_CAFE;
  localparam logic [31:0] S2  = 32'h0000_BEEF;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  int   n_vec = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  operand_fwd_scoreboard_if #(.CNT_W(2))      ifa ();
  operand_fwd_scoreboard_if #(.PIPE_DEPTH(5)) ifb ();

  operand_fwd_scoreboard #(.CNT_W(2)) u_dut_a (
    .clk     (clk),
    .aresetn (aresetn),
    .bus     (ifa.slave)
  );

  operand_fwd_scoreboard #(.PIPE_DEPTH(5), .MEM_READY_SLOT(2)) u_dut_b (
    .clk     (clk),
    .aresetn (aresetn),
    .bus     (ifb.slave)
  );

  typedef struct {
    logic        iv;
    logic [4:0]  idest;
    logic [1:0]  isrc;
    logic        fl;
    logic [1:0]  used;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [1:0]  e_sel0;
    logic [1:0]  e_sel1;
    logic [31:0] e_d0;
    logic [31:0] e_d1;
    logic        e_hz;
    logic [1:0]  e_cnt;
  } vec_t;

  vec_t vt [14];

  function automatic vec_t mk(input logic iv, input logic [4:0] idest, input logic [1:0] isrc,
                              input logic fl, input logic [1:0] used, input logic [4:0] r0,
                              input logic [4:0] r1, input logic [1:0] s0, input logic [1:0] s1,
                              input logic [31:0] d0, input logic [31:0] d1, input logic hz,
                              input logic [1:0] cnt);
    vec_t v;
    v.iv = iv; v.idest = idest; v.isrc = isrc; v.fl = fl; v.used = used;
    v.r0 = r0; v.r1 = r1; v.e_sel0 = s0; v.e_sel1 = s1; v.e_d0 = d0; v.e_d1 = d1;
    v.e_hz = hz; v.e_cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_a(input vec_t v);
    ifa.i_issue_valid = v.iv;
    ifa.i_issue_dest  = v.idest;
    ifa.i_issue_src   = v.isrc;
    ifa.i_flush       = v.fl;
    ifa.i_src_used    = v.used;
    ifa.i_src_reg     = {v.r1, v.r0};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.i_issue_valid = 1'b0; ifa.i_issue_dest = '0; ifa.i_issue_src = '0;
    ifa.i_flush = 1'b0; ifa.i_src_used = '0; ifa.i_src_reg = '0;
    ifa.i_rf_data = {RF1, RF0};
    ifa.i_slot_data = {S2, S1, S0};
    ifb.i_issue_valid = 1'b0; ifb.i_issue_dest = '0; ifb.i_issue_src = '0;
    ifb.i_flush = 1'b0; ifb.i_src_used = '0; ifb.i_src_reg = '0;
    ifb.i_rf_data = {RF1, RF0};
    ifb.i_slot_data = {32'h5000_0004, 32'h5000_0003, 32'h5000_0002, 32'h5000_0001, 32'h5000_0000};

    //          iv  dest  src            fl  used   r0 r1   sel0 sel1 d0   d1   hz cnt
    vt[0]  = mk(0, 5'd0, DEST_SRC_NONE, 0, 2'b11, 3, 3,   0, 0, RF0, RF1, 0, 0);
    vt[1]  = mk(1, 5'd5, DEST_SRC_ALU,  0, 2'b00, 0, 0,   0, 0, RF0, RF1, 0, 0);
    vt[2]  = mk(1, 5'd7, DEST_SRC_MEM,  0, 2'b01, 5, 0,   1, 0, S0,  RF1, 0, 0);
    vt[3]  = mk(1, 5'd9, DEST_SRC_ALU,  0, 2'b10, 5, 7,   0, 0, RF0, 0,   1, 0);
    vt[4]  = mk(1, 5'd4, DEST_SRC_ALU,  0, 2'b11, 5, 7,   3, 2, S2,  S1,  0, 1);
    vt[5]  = mk(1, 5'd4, DEST_SRC_ALU,  0, 2'b11, 9, 5,   0, 0, RF0, RF1, 0, 1);
    vt[6]  = mk(1, 5'd0, DEST_SRC_ALU,  1, 2'b11, 4, 7,   1, 0, S0,  RF1, 0, 1);
    vt[7]  = mk(1, 5'd6, DEST_SRC_MEM,  1, 2'b11, 4, 0,   3, 0, S2,  RF1, 0, 1);
    vt[8]  = mk(0, 5'd0, DEST_SRC_NONE, 0, 2'b11, 6, 6,   0, 0, 0,   0,   1, 1);
    vt[9]  = mk(1, 5'd8, DEST_SRC_MEM,  0, 2'b01, 6, 0,   2, 0, S1,  RF1, 0, 2);
    vt[10] = mk(0, 5'd0, DEST_SRC_NONE, 0, 2'b01, 8, 0,   0, 0, 0,   RF1, 1, 2);
    vt[11] = mk(1, 5'd8, DEST_SRC_MEM,  0, 2'b01, 8, 0,   2, 0, S1,  RF1, 0, 3);
    vt[12] = mk(0, 5'd0, DEST_SRC_NONE, 0, 2'b01, 8, 0,   0, 0, 0,   RF1, 1, 3);
    vt[13] = mk(1, 5'd10, DEST_SRC_MEM, 0, 2'b01, 8, 0,   2, 0, S1,  RF1, 0, 3);

    // Reset state, checked while reset is held
    repeat (2) @(posedge clk);
    #1;
    ifa.i_src_used = 2'b11; ifa.i_src_reg = {5'd3, 5'd3};
    @(negedge clk);
    chk("reset_hazard", 32'(ifa.o_hazard), 32'd0);
    chk("reset_cnt", 32'(ifa.o_stall_cnt), 32'd0);
    chk("reset_sel", 32'(ifa.o_src_sel), 32'd0);
    chk("reset_cnt_b", ifb.o_stall_cnt, 32'd0);
    $display("reset: hazard=%0d cnt=%0d sel=%0h", ifa.o_hazard, ifa.o_stall_cnt, ifa.o_src_sel);
    @(posedge clk);
    #1 aresetn = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      drive_a(vt[i]);
      @(negedge clk);
      chk($sformatf("v%0d_sel0", i), 32'(ifa.o_src_sel[1:0]), 32'(vt[i].e_sel0));
      chk($sformatf("v%0d_sel1", i), 32'(ifa.o_src_sel[3:2]), 32'(vt[i].e_sel1));
      chk($sformatf("v%0d_data0", i), ifa.o_src_data[31:0], vt[i].e_d0);
      chk($sformatf("v%0d_data1", i), ifa.o_src_data[63:32], vt[i].e_d1);
      chk($sformatf("v%0d_hazard", i), 32'(ifa.o_hazard), 32'(vt[i].e_hz));
      chk($sformatf("v%0d_cnt", i), 32'(ifa.o_stall_cnt), 32'(vt[i].e_cnt));
      $display("vec %0d: sel=%0d/%0d data=%h/%h hazard=%0d cnt=%0d", i,
               ifa.o_src_sel[1:0], ifa.o_src_sel[3:2], ifa.o_src_data[31:0],
               ifa.o_src_data[63:32], ifa.o_hazard, ifa.o_stall_cnt);
    end

    // Async reset in the middle of a load-use stall (x10 load sits in slot 0)
    @(posedge clk);
    #1;
    ifa.i_issue_valid = 1'b0; ifa.i_flush = 1'b0;
    ifa.i_src_used = 2'b01; ifa.i_src_reg = {5'd0, 5'd10};
    #3;
    chk("arst_pre_hazard", 32'(ifa.o_hazard), 32'd1);
    aresetn = 1'b0;
    #1;
    chk("arst_hazard", 32'(ifa.o_hazard), 32'd0);
    chk("arst_cnt", 32'(ifa.o_stall_cnt), 32'd0);
    chk("arst_sel0", 32'(ifa.o_src_sel[1:0]), 32'd0);
    chk("arst_data0", ifa.o_src_data[31:0], RF0);
    $display("async reset: hazard=%0d cnt=%0d sel0=%0d", ifa.o_hazard, ifa.o_stall_cnt, ifa.o_src_sel[1:0]);
    #2 aresetn = 1'b1;
    @(negedge clk);
    chk("arst_after_hazard", 32'(ifa.o_hazard), 32'd0);
    chk("arst_after_cnt", 32'(ifa.o_stall_cnt), 32'd0);
    $display("after reset release: hazard=%0d cnt=%0d", ifa.o_hazard, ifa.o_stall_cnt);
    ifa.i_src_used = 2'b00;

    // Deep pipe: load in slot 0 and 1 stalls, then forwarded from slots 2..4, then RF
    @(posedge clk);
    #1;
    ifb.i_issue_valid = 1'b1; ifb.i_issue_dest = 5'd7; ifb.i_issue_src = DEST_SRC_MEM;
    @(negedge clk);
    chk("b_issue_hazard", 32'(ifb.o_hazard), 32'd0);
    for (int c = 1; c <= 6; c++) begin
      logic        e_hz;
      logic [2:0]  e_sel;
      logic [31:0] e_d;
      logic [31:0] e_cnt;
      @(posedge clk);
      #1;
      ifb.i_issue_valid = 1'b0; ifb.i_issue_dest = '0; ifb.i_issue_src = DEST_SRC_NONE;
      ifb.i_src_used = 2'b01; ifb.i_src_reg = {5'd0, 5'd7};
      e_hz  = (c <= 2);
      e_sel = (c <= 2) ? 3'd0 : (c == 6) ? 3'd0 : 3'(c);
      e_d   = (c <= 2) ? 32'd0 : (c == 6) ? RF0 : (32'h5000_0000 + 32'(c - 1));
      e_cnt = (c == 1) ? 32'd0 : (c == 2) ? 32'd1 : 32'd2;
      @(negedge clk);
      chk($sformatf("b%0d_hazard", c), 32'(ifb.o_hazard), 32'(e_hz));
      chk($sformatf("b%0d_sel0", c), 32'(ifb.o_src_sel[2:0]), 32'(e_sel));
      chk($sformatf("b%0d_data0", c), ifb.o_src_data[31:0], e_d);
      chk($sformatf("b%0d_cnt", c), ifb.o_stall_cnt, e_cnt);
      $display("deep %0d: hazard=%0d sel0=%0d data0=%h cnt=%0d", c, ifb.o_hazard,
               ifb.o_src_sel[2:0], ifb.o_src_data[31:0], ifb.o_stall_cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/operand_fwd_scoreboard.md
Name: operand_fwd_scoreboard

Overview:
- Parametrised operand-forwarding and load-use hazard unit that sits beside the decode stage.
- Keeps a shift-register scoreboard of in-flight writers, one slot per post-decode stage (EX, ME, WB, ...).
- For each of N_SRC source operands it selects the youngest pending producer or the register file, and raises a stall when the producer's data is not yet available.
- Generalises decode-stage forwarding to any pipeline depth, any source count, and any load latency, and adds flush and a stall-cycle counter.

Parameters:
REG_IDX_W, 5, register index width
WORD_W, 32, data word width
N_SRC, 2, number of source operands resolved per cycle
PIPE_DEPTH, 3, post-decode stages holding writers (slot 0 = EX ... slot PIPE_DEPTH-1 = WB)
MEM_READY_SLOT, 1, first slot whose output carries load data (must be < PIPE_DEPTH)
CNT_W, 32, stall counter width

Ports:
clk  in  1  clock
aresetn  in  1  asynchronous active-low reset
i_issue_valid  in  1  decode stage issues an instruction into slot 0 this cycle
i_issue_dest  in  REG_IDX_W  destination register of the issued instruction
i_issue_src  in  DEST_SRC_W  DEST_SRC_ALU, DEST_SRC_MEM or DEST_SRC_NONE
i_flush  in  1  kill the instruction currently in slot 0 (branch redirect)
i_src_reg  in  N_SRC*REG_IDX_W  source register indices (operand j at bits [j*REG_IDX_W +: REG_IDX_W])
i_src_used  in  N_SRC  operand j actually reads a GPR
i_rf_data  in  N_SRC*WORD_W  register-file read data per operand
i_slot_data  in  PIPE_DEPTH*WORD_W  result word leaving each slot's stage (ALU result, or load data from MEM_READY_SLOT on)
o_src_data  out  N_SRC*WORD_W  resolved operand data
o_src_sel  out  N_SRC*SEL_W  0 = register file, k+1 = forwarded from slot k; SEL_W = clog2(PIPE_DEPTH+1)
o_hazard  out  1  stall decode this cycle
o_stall_cnt  out  CNT_W  saturating count of hazard cycles

Behaviour:
- Reset (aresetn low, asynchronous): all slot valid bits 0, dest and src fields 0, o_stall_cnt 0. With no valid slots the combinational outputs are o_hazard=0 and o_src_sel=0.
- Slot update, every posedge:
  - slot k+1 <= slot k, for k = 0..PIPE_DEPTH-2; slot PIPE_DEPTH-1 retires.
  - slot 0 <= {valid = i_issue_valid & ~o_hazard & (i_issue_dest != 0) & (i_issue_src != NONE), dest, src}.
  - When o_hazard=1, slot 0 receives a bubble and downstream slots still advance.
- Flush: when i_flush=1, the value being shifted into slot 1 has valid forced to 0. A new issue into slot 0 in the same cycle is still accepted.
- Operand resolution (combinational, per operand j):
  - If i_src_used[j]=0 or i_src_reg[j]=0: sel=0, data=i_rf_data[j], no hazard.
  - Otherwise find the lowest k with slot k valid and dest == i_src_reg[j]. This is the youngest producer; older matches are ignored.
  - If the match has src=MEM and k < MEM_READY_SLOT: operand hazard=1, sel=0, data=0.
  - Otherwise sel=k+1, data=i_slot_data[k].
  - No match: sel=0, data=i_rf_data[j].
- o_hazard is the OR of all operand hazards.
- The last slot (WB) is forwarded because the register file is write-at-edge, not write-through.
- o_stall_cnt increments on each cycle with o_hazard=1 and holds at all-ones.
- Simultaneous issue and hazard: the issue is dropped. Decode holds its instruction and re-presents it.
- Reset mid-operation clears all in-flight tracking immediately.

Decomposition:
- Shared package/header holds DEST_SRC_* encodings, DEST_SRC_W and the SEL encoding constants; the existing config and opcodes headers are reused.
- One sub-module, fwd_operand_resolve: a single-operand priority match and mux, instantiated N_SRC times in a generate loop.
- The slot shift register and stall counter live in the top module.

Test Plan:
- Reset then src x3 used, no issues -> o_src_sel=0, o_src_data=i_rf_data, o_hazard=0, o_stall_cnt=0.
- ALU back-to-back: issue dest x5 ALU; next cycle src0=x5, i_slot_data[0]=0x1234 -> sel0=1, data0=0x1234, no hazard.
- Load-use: issue dest x7 MEM; next cycle src1=x7 -> o_hazard=1, stall_cnt=1. Following cycle (x7 in slot 1, i_slot_data[1]=0xCAFE) -> hazard=0, sel1=2, data1=0xCAFE.
- Youngest wins: issue x4 ALU then x4 ALU; read x4 -> sel=1 (slot 0), not 2. Flush slot 0 on the same cycle instead -> next-cycle read of x4 gives sel=3.
- x0 and depth: issue dest x0 -> never tracked. Run with PIPE_DEPTH=5, MEM_READY_SLOT=2 -> a load consumer stalls 2 cycles, then sel=3.
- Counter saturation and async reset: CNT_W=2 with 5 hazard cycles -> o_stall_cnt=3. Drop aresetn mid-stall -> hazard=0 and counter=0 before the next clock edge.
